// File: rtl/armleo_axi_read_arbiter.sv
// rtl/armleo_axi_read_arbiter.sv - round-robin arbiter sharing one AXI4 read port between hosts
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   upstream_axi_ar*              per-host AR channels, packed (host i in slice i)
//   upstream_axi_rvalid/rready    per-host R handshake
//   upstream_axi_rdata/rresp/
//     rid/rlast                   R payload broadcast to every host
//   downstream_axi_ar*            AR channel toward the shared target
//   downstream_axi_r*             R channel from the shared target
module armleo_axi_read_arbiter #(
  parameter int HOST_NUM   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic [HOST_NUM-1:0]            upstream_axi_arvalid,
  output logic [HOST_NUM-1:0]            upstream_axi_arready,
  input  logic [HOST_NUM*ADDR_WIDTH-1:0] upstream_axi_araddr,
  input  logic [HOST_NUM*8-1:0]          upstream_axi_arlen,
  input  logic [HOST_NUM*3-1:0]          upstream_axi_arsize,
  input  logic [HOST_NUM*2-1:0]          upstream_axi_arburst,
  input  logic [HOST_NUM-1:0]            upstream_axi_arlock,
  input  logic [HOST_NUM*ID_WIDTH-1:0]   upstream_axi_arid,
  input  logic [HOST_NUM*3-1:0]          upstream_axi_arprot,

  output logic [HOST_NUM-1:0]            upstream_axi_rvalid,
  input  logic [HOST_NUM-1:0]            upstream_axi_rready,
  output logic [DATA_WIDTH-1:0]          upstream_axi_rdata,
  output logic [1:0]                     upstream_axi_rresp,
  output logic [ID_WIDTH-1:0]            upstream_axi_rid,
  output logic                           upstream_axi_rlast,

  output logic                           downstream_axi_arvalid,
  input  logic                           downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0]          downstream_axi_araddr,
  output logic [7:0]                     downstream_axi_arlen,
  output logic [2:0]                     downstream_axi_arsize,
  output logic [1:0]                     downstream_axi_arburst,
  output logic                           downstream_axi_arlock,
  output logic [ID_WIDTH-1:0]            downstream_axi_arid,
  output logic [2:0]                     downstream_axi_arprot,

  input  logic                           downstream_axi_rvalid,
  output logic                           downstream_axi_rready,
  input  logic [DATA_WIDTH-1:0]          downstream_axi_rdata,
  input  logic [1:0]                     downstream_axi_rresp,
  input  logic [ID_WIDTH-1:0]            downstream_axi_rid,
  input  logic                           downstream_axi_rlast
);

  localparam int IDX_W = $clog2(HOST_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [IDX_W-1:0] pick;
  int               cand;
  int               gi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      // last starts at the highest index so the search begins at host 0
      last  <= IDX_W'(HOST_NUM - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // Round-robin search from last+1 upward with wrap-around. Iterating from
  // the farthest candidate down lets the nearest requester win the final write.
  always_comb begin
    pick = grant;
    cand = 0;
    for (int i = HOST_NUM; i >= 1; i--) begin
      cand = (int'(last) + i) % HOST_NUM;
      if (upstream_axi_arvalid[cand]) begin
        pick = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    gi        = int'(grant);

    upstream_axi_arready   = '0;
    upstream_axi_rvalid    = '0;
    downstream_axi_arvalid = 1'b0;
    downstream_axi_araddr  = '0;
    downstream_axi_arlen   = '0;
    downstream_axi_arsize  = '0;
    downstream_axi_arburst = '0;
    downstream_axi_arlock  = 1'b0;
    downstream_axi_arid    = '0;
    downstream_axi_arprot  = '0;
    downstream_axi_rready  = 1'b0;
    upstream_axi_rdata     = downstream_axi_rdata;
    upstream_axi_rresp     = downstream_axi_rresp;
    upstream_axi_rid       = downstream_axi_rid;
    upstream_axi_rlast     = downstream_axi_rlast;

    case (state)
      IDLE: begin
        if (|upstream_axi_arvalid) begin
          grant_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        downstream_axi_arvalid = upstream_axi_arvalid[gi];
        downstream_axi_araddr  = upstream_axi_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        downstream_axi_arlen   = upstream_axi_arlen[gi*8 +: 8];
        downstream_axi_arsize  = upstream_axi_arsize[gi*3 +: 3];
        downstream_axi_arburst = upstream_axi_arburst[gi*2 +: 2];
        downstream_axi_arlock  = upstream_axi_arlock[gi];
        downstream_axi_arid    = upstream_axi_arid[gi*ID_WIDTH +: ID_WIDTH];
        downstream_axi_arprot  = upstream_axi_arprot[gi*3 +: 3];
        upstream_axi_arready[gi] = downstream_axi_arready;
        if (downstream_axi_arvalid && downstream_axi_arready) begin
          last_nxt  = grant;
          state_nxt = DATA;
        end
      end
      DATA: begin
        upstream_axi_rvalid[gi] = downstream_axi_rvalid;
        downstream_axi_rready   = upstream_axi_rready[gi];
        if (downstream_axi_rvalid && downstream_axi_rready && downstream_axi_rlast) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The R payload is a pass-through, so it has to be squashed explicitly
    // to keep every output at zero while reset is held.
    if (rst) begin
      upstream_axi_rdata = '0;
      upstream_axi_rresp = '0;
      upstream_axi_rid   = '0;
      upstream_axi_rlast = 1'b0;
    end
  end

endmodule

// File: tb/tb_armleo_axi_read_arbiter.sv
// tb/tb_armleo_axi_read_arbiter.sv - directed self-checking bench for armleo_axi_read_arbiter
module tb_armleo_axi_read_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  up_arvalid;
  logic [1:0]  up_arready;
  logic [63:0] up_araddr;
  logic [15:0] up_arlen;
  logic [5:0]  up_arsize;
  logic [3:0]  up_arburst;
  logic [1:0]  up_arlock;
  logic [7:0]  up_arid;
  logic [5:0]  up_arprot;
  logic [1:0]  up_rvalid;
  logic [1:0]  up_rready;
  logic [31:0] up_rdata;
  logic [1:0]  up_rresp;
  logic [3:0]  up_rid;
  logic        up_rlast;
  logic        ds_arvalid;
  logic        ds_arready;
  logic [31:0] ds_araddr;
  logic [7:0]  ds_arlen;
  logic [2:0]  ds_arsize;
  logic [1:0]  ds_arburst;
  logic        ds_arlock;
  logic [3:0]  ds_arid;
  logic [2:0]  ds_arprot;
  logic        ds_rvalid;
  logic        ds_rready;
  logic [31:0] ds_rdata;
  logic [1:0]  ds_rresp;
  logic [3:0]  ds_rid;
  logic        ds_rlast;

  int checks = 0;
  int errors = 0;
  int beats;

  armleo_axi_read_arbiter #(
    .HOST_NUM(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
    .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen),
    .upstream_axi_arsize(up_arsize), .upstream_axi_arburst(up_arburst),
    .upstream_axi_arlock(up_arlock), .upstream_axi_arid(up_arid),
    .upstream_axi_arprot(up_arprot),
    .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready),
    .upstream_axi_rdata(up_rdata), .upstream_axi_rresp(up_rresp),
    .upstream_axi_rid(up_rid), .upstream_axi_rlast(up_rlast),
    .downstream_axi_arvalid(ds_arvalid), .downstream_axi_arready(ds_arready),
    .downstream_axi_araddr(ds_araddr), .downstream_axi_arlen(ds_arlen),
    .downstream_axi_arsize(ds_arsize), .downstream_axi_arburst(ds_arburst),
    .downstream_axi_arlock(ds_arlock), .downstream_axi_arid(ds_arid),
    .downstream_axi_arprot(ds_arprot),
    .downstream_axi_rvalid(ds_rvalid), .downstream_axi_rready(ds_rready),
    .downstream_axi_rdata(ds_rdata), .downstream_axi_rresp(ds_rresp),
    .downstream_axi_rid(ds_rid), .downstream_axi_rlast(ds_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int h, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id);
    up_araddr[h*32 +: 32] = addr;
    up_arlen[h*8 +: 8]    = len;
    up_arsize[h*3 +: 3]   = 3'd2;
    up_arburst[h*2 +: 2]  = 2'd1;
    up_arlock[h]          = 1'b0;
    up_arid[h*4 +: 4]     = id;
    up_arprot[h*3 +: 3]   = 3'(h + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_arvalid = '0;
    ds_arready = 1'b0;
    ds_rvalid  = 1'b0;
    ds_rlast   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    up_arvalid = '0; up_rready = '0;
    up_araddr = '0; up_arlen = '0; up_arsize = '0; up_arburst = '0;
    up_arlock = '0; up_arid = '0; up_arprot = '0;
    ds_arready = 1'b0; ds_rvalid = 1'b0; ds_rdata = '0; ds_rresp = '0;
    ds_rid = '0; ds_rlast = 1'b0;

    // reset state
    step();
    chk("rst_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("rst_up_arready", 64'(up_arready), 64'd0);
    chk("rst_up_rvalid", 64'(up_rvalid), 64'd0);
    chk("rst_ds_rready", 64'(ds_rready), 64'd0);
    do_reset();

    // single read from host 1
    set_host(1, 32'h100, 8'd0, 4'd3);
    up_arvalid = 2'b10;
    #1;
    chk("single_idle_arvalid", 64'(ds_arvalid), 64'd0);
    step();
    chk("single_ds_arvalid", 64'(ds_arvalid), 64'd1);
    chk("single_araddr", 64'(ds_araddr), 64'h100);
    chk("single_arlen", 64'(ds_arlen), 64'd0);
    chk("single_arid", 64'(ds_arid), 64'd3);
    chk("single_arprot", 64'(ds_arprot), 64'd2);
    chk("single_arready_blocked", 64'(up_arready), 64'd0);
    ds_arready = 1'b1;
    #1;
    chk("single_arready", 64'(up_arready), 64'b10);
    step();
    up_arvalid = 2'b00;
    ds_arready = 1'b0;
    up_rready = 2'b10;
    ds_rvalid = 1'b1; ds_rdata = 32'hDEADBEEF; ds_rlast = 1'b1; ds_rid = 4'd3; ds_rresp = 2'd0;
    #1;
    chk("single_rvalid", 64'(up_rvalid), 64'b10);
    chk("single_rdata", 64'(up_rdata), 64'hDEADBEEF);
    chk("single_rid", 64'(up_rid), 64'd3);
    chk("single_ds_rready", 64'(ds_rready), 64'd1);
    step();
    ds_rvalid = 1'b0; ds_rlast = 1'b0;
    #1;
    chk("single_back_idle_rvalid", 64'(up_rvalid), 64'd0);
    chk("single_back_idle_arvalid", 64'(ds_arvalid), 64'd0);

    // simultaneous requests after reset: host 0 first
    do_reset();
    set_host(0, 32'h200, 8'd3, 4'd1);
    set_host(1, 32'h300, 8'd0, 4'd2);
    up_arvalid = 2'b11;
    step();
    chk("simul_first_addr", 64'(ds_araddr), 64'h200);
    chk("simul_first_len", 64'(ds_arlen), 64'd3);
    ds_arready = 1'b1;
    #1;
    chk("simul_arready_h0_only", 64'(up_arready), 64'b01);
    step();
    up_arvalid = 2'b10;
    ds_arready = 1'b0;
    up_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      ds_rvalid = 1'b1;
      ds_rdata = 32'(b);
      ds_rlast = (b == 3);
      #1;
      chk("simul_burst_rvalid", 64'(up_rvalid), 64'b01);
      chk("simul_h1_held", 64'(up_arready), 64'd0);
      step();
    end
    ds_rvalid = 1'b0; ds_rlast = 1'b0;
    #1;
    chk("simul_bubble", 64'(ds_arvalid), 64'd0);
    step();
    chk("simul_second_addr", 64'(ds_araddr), 64'h300);
    chk("simul_second_arvalid", 64'(ds_arvalid), 64'd1);
    ds_arready = 1'b1;
    step();
    up_arvalid = 2'b00;
    ds_arready = 1'b0;
    ds_rvalid = 1'b1; ds_rlast = 1'b1;
    #1;
    chk("simul_second_rvalid", 64'(up_rvalid), 64'b10);
    step();
    ds_rvalid = 1'b0; ds_rlast = 1'b0;

    // fairness: both request continuously, grants alternate 0,1,0,1
    up_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fair_arvalid", 64'(ds_arvalid), 64'd1);
      chk("fair_addr", 64'(ds_araddr), (k % 2 == 0) ? 64'h200 : 64'h300);
      ds_arready = 1'b1;
      step();
      ds_arready = 1'b0;
      ds_rvalid = 1'b1; ds_rlast = 1'b1;
      #1;
      chk("fair_rvalid", 64'(up_rvalid), (k % 2 == 0) ? 64'b01 : 64'b10);
      step();
      ds_rvalid = 1'b0; ds_rlast = 1'b0;
      #1;
      chk("fair_one_bubble", 64'(ds_arvalid), 64'd0);
    end
    up_arvalid = 2'b00;
    step();

    // backpressure on AR then toggling rready during a 4-beat burst
    set_host(0, 32'h400, 8'd3, 4'd5);
    up_arvalid = 2'b01;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_arvalid_stable", 64'(ds_arvalid), 64'd1);
      chk("bp_araddr_stable", 64'(ds_araddr), 64'h400);
      chk("bp_arready_zero", 64'(up_arready), 64'd0);
      step();
    end
    ds_arready = 1'b1;
    step();
    up_arvalid = 2'b00;
    ds_arready = 1'b0;
    beats = 0;
    for (int c = 0; c < 7; c++) begin
      up_rready = {1'b0, (c % 2 == 0)};
      ds_rvalid = 1'b1;
      ds_rdata = 32'(beats);
      ds_rlast = (beats == 3);
      #1;
      chk("bp_rready_mirror", 64'(ds_rready), (c % 2 == 0) ? 64'd1 : 64'd0);
      chk("bp_rvalid", 64'(up_rvalid), 64'b01);
      if (c % 2 == 0) beats++;
      step();
    end
    up_rready = 2'b01;
    #1;
    chk("bp_done_after_rlast", 64'(up_rvalid), 64'd0);
    ds_rvalid = 1'b0; ds_rlast = 1'b0;

    // error passthrough and reset mid-burst
    set_host(1, 32'h500, 8'd3, 4'd7);
    up_arvalid = 2'b10;
    step();
    chk("err_addr", 64'(ds_araddr), 64'h500);
    ds_arready = 1'b1;
    step();
    up_arvalid = 2'b00;
    ds_arready = 1'b0;
    up_rready = 2'b10;
    ds_rvalid = 1'b1; ds_rresp = 2'b10; ds_rlast = 1'b0; ds_rdata = 32'h1111;
    #1;
    chk("err_rresp", 64'(up_rresp), 64'b10);
    chk("err_rvalid", 64'(up_rvalid), 64'b10);
    step();
    ds_rresp = 2'b00; ds_rdata = 32'h2222;
    step();
    ds_rdata = 32'hCAFE;
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", 64'(up_rvalid), 64'd0);
    chk("midrst_ds_rready", 64'(ds_rready), 64'd0);
    chk("midrst_rdata", 64'(up_rdata), 64'd0);
    chk("midrst_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("midrst_arready", 64'(up_arready), 64'd0);
    step();
    ds_rvalid = 1'b0;
    rst = 1'b0;
    set_host(1, 32'h600, 8'd0, 4'd4);
    up_arvalid = 2'b10;
    step();
    chk("post_rst_h1_addr", 64'(ds_araddr), 64'h600);
    ds_arready = 1'b1;
    step();
    up_arvalid = 2'b00;
    ds_arready = 1'b0;
    ds_rvalid = 1'b1; ds_rlast = 1'b1;
    step();
    ds_rvalid = 1'b0; ds_rlast = 1'b0;
    set_host(0, 32'h700, 8'd0, 4'd6);
    up_arvalid = 2'b11;
    step();
    chk("post_rst_tie_h0", 64'(ds_araddr), 64'h700);
    chk("post_rst_tie_id", 64'(ds_arid), 64'd6);
    up_arvalid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/armleo_axi_read_arbiter.md
# armleo_axi_read_arbiter

Round-robin arbiter that shares one downstream AXI4 read port (AR/R channels) between HOST_NUM upstream read hosts. It allows one outstanding read transaction at a time. The grant is locked from AR acceptance until the R beat carrying rlast completes. It sits in front of a single memory or peripheral read port, typically with an AXI register slice on the downstream side to break timing. Write channels are out of scope.

## Interface
Parameters:
- HOST_NUM, 2, number of upstream hosts; legal values are ≥2.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- ID_WIDTH, 4, transaction ID width; IDs pass through unchanged.
- IDX_W, localparam $clog2(HOST_NUM), width of the grant index.

Ports (the HOST_NUM-indexed AR fields are packed, host i occupies slice i):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- upstream_axi_arvalid  in  HOST_NUM  per-host AR valid.
- upstream_axi_arready  out  HOST_NUM  per-host AR ready.
- upstream_axi_araddr/arlen/arsize/arburst/arlock/arid/arprot  in  HOST_NUM×(ADDR_WIDTH/8/3/2/1/ID_WIDTH/3)  per-host AR fields.
- upstream_axi_rvalid  out  HOST_NUM  per-host R valid.
- upstream_axi_rready  in  HOST_NUM  per-host R ready.
- upstream_axi_rdata/rresp/rid/rlast  out  DATA_WIDTH/2/ID_WIDTH/1  R payload, broadcast to all hosts.
- downstream_axi_arvalid/arready/ar*  out/in/out  as AXI4  AR channel toward the target.
- downstream_axi_rvalid/rready/rdata/rresp/rid/rlast  in/out/in/in/in/in  as AXI4  R channel from the target.

## Operation
The arbiter has three states: IDLE, ADDR and DATA. It holds two registers, grant (IDX_W bits) and last (IDX_W bits).

- **IDLE:**
  - All arready, all rvalid and downstream arvalid/rready are 0.
  - If any arvalid is set, pick the first set index searching from (last+1) mod HOST_NUM upward with wrap-around. Register that index into grant and go to ADDR.
  - If no arvalid is set, stay in IDLE.
- **ADDR:**
  - downstream_axi_arvalid = upstream_axi_arvalid[grant]. This is always 1, because AXI forbids dropping arvalid before the handshake.
  - downstream_axi_ar* = the fields of host grant.
  - upstream_axi_arready[grant] = downstream_axi_arready; all other arready are 0.
  - On arvalid&arready, set last <= grant and go to DATA.
- **DATA:**
  - upstream_axi_rvalid[grant] = downstream_axi_rvalid; all other rvalid are 0.
  - downstream_axi_rready = upstream_axi_rready[grant].
  - On rvalid&rready&rlast, go to IDLE.
  - Beats without rlast keep the state in DATA.
- Requests from non-granted hosts are held off by their arready being 0 and are never dropped.
- rresp (including SLVERR/DECERR) and rid are forwarded unmodified. The arbiter does not inspect arlen; it relies on rlast alone.
- rready from non-granted hosts is ignored.
- **Reset:**
  - state=IDLE, grant=0, last=HOST_NUM-1, so host 0 has first priority.
  - All outputs are 0 while rst is high, including in the middle of a burst.
  - Any partially transferred burst is abandoned. The downstream target must be reset together with the arbiter.

## Timing
- Arbitration latency: 1 cycle. If arvalid rises in IDLE at cycle N, downstream arvalid is 1 at cycle N+1.
- Minimum upstream AR handshake: cycle N+1, if downstream arready is 1.
- R path is combinational through the mux; it adds zero cycles of latency.
- AR ready and AR payload are combinational from upstream to downstream (no register).
- Back-to-back transactions: one IDLE bubble cycle after the rlast handshake, before the next ADDR.
- Throughput inside a burst: 1 beat/cycle when both sides are ready.
- Only state, grant and last are registered. There is no combinational path from downstream arready to downstream arvalid.

## Test plan
- **Single read:** host 1 issues araddr=0x100, arlen=0, arid=3.
  - Downstream sees arvalid one cycle later with identical fields.
  - One R beat with rdata=0xDEADBEEF, rlast=1 reaches only host 1 (rvalid=2'b10).
  - State returns to IDLE.
- **Simultaneous requests:** after reset, hosts 0 and 1 assert arvalid in the same cycle.
  - Host 0 is served first (arlen=3, 4 beats), then host 1.
  - Host 1's arvalid stays high and its arready stays 0 until host 0's rlast.
- **Fairness:** host 0 requests continuously and host 1 requests continuously.
  - Grants alternate 0,1,0,1 over 4 transactions.
  - Each transaction gap is exactly one IDLE cycle.
- **Backpressure:**
  - Downstream arready is held at 0 for 5 cycles: downstream arvalid and fields stay stable and upstream arready stays 0.
  - During a 4-beat burst, host rready toggles 1,0,1,0: downstream rready mirrors it, and exactly 4 beats complete with rlast on the 4th.
- **Error passthrough and reset mid-burst:**
  - An R beat with rresp=2'b10 is forwarded unchanged.
  - Asserting rst after beat 2 of 4 drives all outputs to 0 asynchronously.
  - After release, a host 1 request is granted, and host 0 has priority on a tie.
